// File: rtl/forex_result_reader.sv
// ---------------------------------------------------------------------------
// forex_result_reader
//
// Read-side Avalon-MM slave that hands arbitrage results from the Container
// engine to the HPS. Container streams each negative cycle as a sequence of
// node IDs; the final node carries res_last. Beats are buffered in a FIFO,
// complete cycles are counted, and a level interrupt is raised while at
// least one complete cycle is waiting and the interrupt is enabled.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   res_valid/res_ready   Container beat handshake (accept on valid&&ready)
//   res_node, res_last    beat payload: node ID and end-of-cycle marker
//   flush                 discard all buffered results
//   chipselect, read,
//   write, address,
//   writedata, readdata   Avalon-MM slave (readdata registered, 1-cycle)
//   irq                   level interrupt
//
// Register map:
//   0 STATUS (ro)  [CNT_W-1:0]=count [8]=empty [9]=full
//                  [23:16]=cycles_pending [24]=irq_en
//   1 DATA   (rd pops) {valid, last, 22'b0, node[7:0]}; 0 when empty
//   2 CTRL   wr: bit0=irq_en, bit1=flush (self-clearing); rd: {31'b0,irq_en}
// ---------------------------------------------------------------------------
module forex_result_reader #(
    parameter int NODE_W = 5,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [NODE_W-1:0] res_node,
    input  logic              res_last,
    input  logic              flush,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [2:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = NODE_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating counter helpers for cycles_pending.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_W'(1);
    endfunction

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count, cycles_pending;
    logic             irq_en;

    logic             full, empty;
    logic             rd_req, wr_req;
    logic             flush_all, push, pop;
    logic             cyc_inc, cyc_dec;
    logic [ENT_W-1:0] rd_entry;
    logic [31:0]      rd_data_next;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:2];

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign res_ready = !full;

    assign rd_req    = chipselect && read;
    assign wr_req    = chipselect && write;
    assign flush_all = flush || (wr_req && address == 3'd2 && writedata[1]);

    assign push      = res_valid && !full;
    assign pop       = rd_req && address == 3'd1 && !empty;
    assign rd_entry  = mem[rptr];

    assign cyc_inc   = push && res_last;
    assign cyc_dec   = pop && rd_entry[ENT_W-1];

    // Read mux; a DATA read that coincides with a flush returns 0.
    always_comb begin
        rd_data_next = '0;
        case (address)
            3'd0: begin
                rd_data_next[CNT_W-1:0] = count;
                rd_data_next[8]         = empty;
                rd_data_next[9]         = full;
                rd_data_next[23:16]     = 8'(cycles_pending);
                rd_data_next[24]        = irq_en;
            end
            3'd1: begin
                if (!empty && !flush_all) begin
                    rd_data_next[31]  = 1'b1;
                    rd_data_next[30]  = rd_entry[ENT_W-1];
                    rd_data_next[7:0] = 8'(rd_entry[NODE_W-1:0]);
                end
            end
            3'd2: rd_data_next[0] = irq_en;
            default: rd_data_next = '0;
        endcase
    end

    // FIFO storage carries no reset; only pointers and count qualify it.
    always_ff @(posedge clk) begin
        if (push && !flush_all)
            mem[wptr] <= {res_last, res_node};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            cycles_pending <= '0;
        end else if (flush_all) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            cycles_pending <= '0;
        end else begin
            if (push)
                wptr <= wptr + PTR_W'(1);
            if (pop)
                rptr <= rptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            // Simultaneous last push and last pop cancel.
            if (cyc_inc && !cyc_dec)
                cycles_pending <= sat_inc(cycles_pending);
            else if (cyc_dec && !cyc_inc)
                cycles_pending <= sat_dec(cycles_pending);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en   <= 1'b0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_req && address == 3'd2)
                irq_en <= writedata[0];
            if (rd_req)
                readdata <= rd_data_next;
            irq <= irq_en && (cycles_pending != '0);
        end
    end

endmodule

// File: tb/tb_forex_result_reader.sv
module tb_forex_result_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_node;
    logic        res_last;
    logic        flush;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int tests  = 0;
    int failed = 0;

    forex_result_reader #(.NODE_W(5), .DEPTH(16), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_node   (res_node),
        .res_last   (res_last),
        .flush      (flush),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] node, input logic last);
        res_valid = 1'b1;
        res_node  = node;
        res_last  = last;
        tick();
        res_valid = 1'b0;
        res_last  = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    initial begin
        reset = 1'b1; res_valid = 1'b0; res_node = '0; res_last = 1'b0;
        flush = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ready", 32'(res_ready), 32'h1);
        rd(3'd0);
        check("rst_status", readdata, 32'h0000_0100);

        // One three-node cycle with interrupt enabled
        push(5'd3, 1'b0);
        push(5'd7, 1'b0);
        push(5'd12, 1'b1);
        wr(3'd2, 32'h1);
        rd(3'd0);
        check("cyc_status", readdata, 32'h0101_0003);
        check("cyc_irq_on", 32'(irq), 32'h1);
        rd(3'd1);
        check("cyc_data0", readdata, 32'h8000_0003);
        rd(3'd1);
        check("cyc_data1", readdata, 32'h8000_0007);
        rd(3'd1);
        check("cyc_data2", readdata, 32'hC000_000C);
        rd(3'd0);
        check("cyc_irq_off", 32'(irq), 32'h0);
        check("cyc_empty", readdata, 32'h0100_0100);

        // Fill to full, hold the 17th beat
        for (int i = 0; i < 16; i++) push(5'(i), 1'b0);
        check("full_ready", 32'(res_ready), 32'h0);
        rd(3'd0);
        check("full_status", readdata, 32'h0100_0210);
        res_valid = 1'b1; res_node = 5'd20; res_last = 1'b0;
        tick(); tick();
        check("held_ready", 32'(res_ready), 32'h0);
        rd(3'd1);
        check("full_pop", readdata, 32'h8000_0000);
        check("pop_ready", 32'(res_ready), 32'h1);
        tick();
        res_valid = 1'b0;
        check("held_taken", 32'(res_ready), 32'h0);
        rd(3'd0);
        check("held_count", readdata, 32'h0100_0210);
        for (int i = 1; i < 16; i++) begin
            rd(3'd1);
            check($sformatf("drain%0d", i), readdata, 32'h8000_0000 | 32'(i));
        end
        rd(3'd1);
        check("drain_held", readdata, 32'h8000_0014);

        // Read of empty FIFO
        rd(3'd1);
        check("empty_data", readdata, 32'h0);
        rd(3'd0);
        check("empty_status", readdata, 32'h0100_0100);
        push(5'd9, 1'b1);
        rd(3'd1);
        check("after_empty", readdata, 32'hC000_0009);

        // Simultaneous push and pop, both last
        push(5'd6, 1'b1);
        res_valid = 1'b1; res_node = 5'd5; res_last = 1'b1;
        chipselect = 1'b1; read = 1'b1; address = 3'd1;
        tick();
        res_valid = 1'b0; res_last = 1'b0; chipselect = 1'b0; read = 1'b0;
        check("simul_pop", readdata, 32'hC000_0006);
        rd(3'd0);
        check("simul_status", readdata, 32'h0101_0001);
        rd(3'd1);
        check("simul_next", readdata, 32'hC000_0005);

        // Flush input coincident with a push
        push(5'd1, 1'b0);
        push(5'd2, 1'b0);
        push(5'd3, 1'b1);
        push(5'd4, 1'b0);
        rd(3'd0);
        check("pre_flush", readdata, 32'h0101_0004);
        flush = 1'b1; res_valid = 1'b1; res_node = 5'd10; res_last = 1'b1;
        tick();
        flush = 1'b0; res_valid = 1'b0; res_last = 1'b0;
        rd(3'd0);
        check("flush_status", readdata, 32'h0100_0100);
        check("flush_irq", 32'(irq), 32'h0);
        rd(3'd1);
        check("flush_data", readdata, 32'h0);

        // CTRL-bit flush, CTRL readback, unmapped address
        push(5'd11, 1'b0);
        push(5'd12, 1'b1);
        wr(3'd2, 32'h3);
        rd(3'd0);
        check("ctrl_flush", readdata, 32'h0100_0100);
        rd(3'd2);
        check("ctrl_rd1", readdata, 32'h1);
        wr(3'd2, 32'h0);
        rd(3'd2);
        check("ctrl_rd0", readdata, 32'h0);
        rd(3'd5);
        check("unmapped", readdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
